// File: rtl/xsim_dma_arb_pkg.sv
// Shared types and widths for the xsim DMA port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xsim_dma_arb_pkg;

    localparam int DMA_WORD_W = 32;
    localparam int DMA_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        DELIVER  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/xsim_rr_arbiter.sv
// Generic round-robin pick: first requester after ptr, wrapping, wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller qualifies req and decides whether to use gnt.
module xsim_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int   cand;
    logic found;

    // Scan ptr+1, ptr+2, ... (mod N) and take the first active requester
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/xsim_dma_arbiter.sv
// Shares the xsim DMA port among NCLIENTS engines; one read in flight, data routed to owner.
// Latency: write issued in grant cycle; read data latched grant+1, rsp_valid from grant+2.
// Backpressure: grants only in IDLE; reads wait on dma_rdy_readrequest; DELIVER holds until rsp_ready.
module xsim_dma_arbiter
    import xsim_dma_arb_pkg::*;
#(
    parameter int NCLIENTS = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NCLIENTS-1:0]            req_valid,
    output logic [NCLIENTS-1:0]            req_ready,
    input  logic [NCLIENTS-1:0]            req_write,
    input  logic [DMA_WORD_W*NCLIENTS-1:0] req_handle,
    input  logic [DMA_WORD_W*NCLIENTS-1:0] req_addr,
    input  logic [DMA_WORD_W*NCLIENTS-1:0] req_data,
    input  logic [DMA_BE_W*NCLIENTS-1:0]   req_be,
    output logic [NCLIENTS-1:0]            rsp_valid,
    input  logic [NCLIENTS-1:0]            rsp_ready,
    output logic [DMA_WORD_W-1:0]          rsp_data,
    input  logic                           dma_rdy_readrequest,
    output logic                           dma_en_readrequest,
    output logic [DMA_WORD_W-1:0]          dma_readrequest_addr,
    output logic [DMA_WORD_W-1:0]          dma_readrequest_handle,
    input  logic                           dma_rdy_readresponse,
    output logic                           dma_en_readresponse,
    input  logic [DMA_WORD_W-1:0]          dma_readresponse_data,
    output logic                           dma_en_write32,
    output logic [DMA_WORD_W-1:0]          dma_write32_addr,
    output logic [DMA_WORD_W-1:0]          dma_write32_handle,
    output logic [DMA_WORD_W-1:0]          dma_write32_data,
    output logic [DMA_BE_W-1:0]            dma_write32_byteenable,
    output logic [31:0]                    read_count,
    output logic [31:0]                    write_count,
    output logic                           timeout_err
);

    localparam int IW  = $clog2(NCLIENTS);
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_MAX  = WCW'(TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    arb_state_t           state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        owner;
    logic [WCW-1:0]       wait_cnt;
    logic [NCLIENTS-1:0]  elig;
    logic [NCLIENTS-1:0]  gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 idle_live;
    logic                 read_ok;
    logic                 grant;
    logic                 gnt_write;

    logic [DMA_WORD_W-1:0] addr_a   [NCLIENTS];
    logic [DMA_WORD_W-1:0] handle_a [NCLIENTS];
    logic [DMA_WORD_W-1:0] data_a   [NCLIENTS];
    logic [DMA_BE_W-1:0]   be_a     [NCLIENTS];

    for (genvar i = 0; i < NCLIENTS; i++) begin : g_unpack
        assign addr_a[i]   = req_addr[DMA_WORD_W*i +: DMA_WORD_W];
        assign handle_a[i] = req_handle[DMA_WORD_W*i +: DMA_WORD_W];
        assign data_a[i]   = req_data[DMA_WORD_W*i +: DMA_WORD_W];
        assign be_a[i]     = req_be[DMA_BE_W*i +: DMA_BE_W];
    end

    // A pending response in IDLE is stale and must be drained before a new read issues
    assign idle_live = !RST && (state == IDLE);
    assign read_ok   = dma_rdy_readrequest && !dma_rdy_readresponse;
    assign elig      = req_valid & (req_write | {NCLIENTS{read_ok}});

    xsim_rr_arbiter #(
        .N  (NCLIENTS),
        .IW (IW)
    ) u_rr (
        .req     (elig),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign grant     = idle_live && (|gnt);
    assign gnt_write = req_write[gnt_idx];

    // Grant, DMA command muxing, response drain and per-owner delivery strobes
    always_comb begin
        req_ready              = grant ? gnt : '0;
        dma_en_write32         = grant && gnt_write;
        dma_en_readrequest     = grant && !gnt_write;
        dma_write32_addr       = dma_en_write32 ? addr_a[gnt_idx]   : '0;
        dma_write32_handle     = dma_en_write32 ? handle_a[gnt_idx] : '0;
        dma_write32_data       = dma_en_write32 ? data_a[gnt_idx]   : '0;
        dma_write32_byteenable = dma_en_write32 ? be_a[gnt_idx]     : '0;
        dma_readrequest_addr   = dma_en_readrequest ? addr_a[gnt_idx]   : '0;
        dma_readrequest_handle = dma_en_readrequest ? handle_a[gnt_idx] : '0;
        dma_en_readresponse    = !RST && dma_rdy_readresponse &&
                                 ((state == IDLE) || (state == WAIT_RSP));
        rsp_valid              = '0;
        if (!RST && (state == DELIVER)) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    // Arbiter FSM with pointer, owner, wait timer, counters and sticky timeout
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            ptr         <= IW'(NCLIENTS - 1);
            owner       <= '0;
            wait_cnt    <= '0;
            rsp_data    <= '0;
            read_count  <= '0;
            write_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        ptr <= gnt_idx;
                        if (gnt_write) begin
                            write_count <= write_count + 32'd1;
                        end else begin
                            owner    <= gnt_idx;
                            wait_cnt <= '0;
                            state    <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (dma_rdy_readresponse) begin
                        rsp_data <= dma_readresponse_data;
                        state    <= DELIVER;
                    end else begin
                        if (wait_cnt < WAIT_MAX) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (wait_cnt >= WAIT_LAST) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                DELIVER: begin
                    if (rsp_ready[owner]) begin
                        read_count <= read_count + 32'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xsim_dma_arbiter.sv
// Directed bench for xsim_dma_arbiter with a hand-driven DMA model.
// Latency: checks same-cycle grants and grant+1/+2 read response timing.
// Backpressure: exercises blocked reads, held rsp_ready, stale drain and timeout.
module tb_xsim_dma_arbiter;

    localparam int NC  = 4;
    localparam int TMO = 8;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NC-1:0]   req_valid;
    logic [NC-1:0]   req_ready;
    logic [NC-1:0]   req_write;
    logic [32*NC-1:0] req_handle;
    logic [32*NC-1:0] req_addr;
    logic [32*NC-1:0] req_data;
    logic [4*NC-1:0]  req_be;
    logic [NC-1:0]   rsp_valid;
    logic [NC-1:0]   rsp_ready;
    logic [31:0]     rsp_data;
    logic            dma_rdy_readrequest;
    logic            dma_en_readrequest;
    logic [31:0]     dma_readrequest_addr;
    logic [31:0]     dma_readrequest_handle;
    logic            dma_rdy_readresponse;
    logic            dma_en_readresponse;
    logic [31:0]     dma_readresponse_data;
    logic            dma_en_write32;
    logic [31:0]     dma_write32_addr;
    logic [31:0]     dma_write32_handle;
    logic [31:0]     dma_write32_data;
    logic [3:0]      dma_write32_byteenable;
    logic [31:0]     read_count;
    logic [31:0]     write_count;
    logic            timeout_err;

    int total = 0;
    int bad   = 0;

    xsim_dma_arbiter #(
        .NCLIENTS (NC),
        .TIMEOUT  (TMO)
    ) dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_write              (req_write),
        .req_handle             (req_handle),
        .req_addr               (req_addr),
        .req_data               (req_data),
        .req_be                 (req_be),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_data               (rsp_data),
        .dma_rdy_readrequest    (dma_rdy_readrequest),
        .dma_en_readrequest     (dma_en_readrequest),
        .dma_readrequest_addr   (dma_readrequest_addr),
        .dma_readrequest_handle (dma_readrequest_handle),
        .dma_rdy_readresponse   (dma_rdy_readresponse),
        .dma_en_readresponse    (dma_en_readresponse),
        .dma_readresponse_data  (dma_readresponse_data),
        .dma_en_write32         (dma_en_write32),
        .dma_write32_addr       (dma_write32_addr),
        .dma_write32_handle     (dma_write32_handle),
        .dma_write32_data       (dma_write32_data),
        .dma_write32_byteenable (dma_write32_byteenable),
        .read_count             (read_count),
        .write_count            (write_count),
        .timeout_err            (timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        req_valid = '0;
        req_write = '0;
    endtask

    task automatic put(input int c, input logic wr, input logic [31:0] h,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid[c]         = 1'b1;
        req_write[c]         = wr;
        req_handle[32*c +: 32] = h;
        req_addr[32*c +: 32]   = a;
        req_data[32*c +: 32]   = d;
        req_be[4*c +: 4]       = be;
    endtask

    initial begin
        RST                   = 1'b1;
        req_valid             = '0;
        req_write             = '0;
        req_handle            = '0;
        req_addr              = '0;
        req_data              = '0;
        req_be                = '0;
        rsp_ready             = '0;
        dma_rdy_readrequest   = 1'b1;
        dma_rdy_readresponse  = 1'b1;
        dma_readresponse_data = 32'h0;
        put(0, 1'b1, 32'h1, 32'h1, 32'h1, 4'hF);
        tick();
        tick();

        // Reset: everything quiet even with a request and a response pending
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_en_write", 32'(dma_en_write32), 32'h0);
        chk("rst_en_rsp", 32'(dma_en_readresponse), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_wr_cnt", write_count, 32'h0);
        chk("rst_rd_cnt", read_count, 32'h0);
        chk("rst_timeout", 32'(timeout_err), 32'h0);
        clr();
        dma_rdy_readresponse = 1'b0;
        RST = 1'b0;

        // Single write from client 2
        put(2, 1'b1, 32'h1, 32'h10, 32'hDEADBEEF, 4'hF);
        #1;
        chk("wr_ready", 32'(req_ready), 32'h4);
        chk("wr_en", 32'(dma_en_write32), 32'h1);
        chk("wr_en_rd", 32'(dma_en_readrequest), 32'h0);
        chk("wr_addr", dma_write32_addr, 32'h10);
        chk("wr_handle", dma_write32_handle, 32'h1);
        chk("wr_data", dma_write32_data, 32'hDEADBEEF);
        chk("wr_be", 32'(dma_write32_byteenable), 32'hF);
        tick();
        clr();
        chk("wr_cnt1", write_count, 32'h1);

        // Single read from client 1 (ptr=2, so 3,0,1 searched)
        put(1, 1'b0, 32'h7, 32'h10, 32'h0, 4'h0);
        #1;
        chk("rd_ready", 32'(req_ready), 32'h2);
        chk("rd_en", 32'(dma_en_readrequest), 32'h1);
        chk("rd_addr", dma_readrequest_addr, 32'h10);
        chk("rd_handle", dma_readrequest_handle, 32'h7);
        tick();
        clr();
        dma_rdy_readresponse  = 1'b1;
        dma_readresponse_data = 32'hDEADBEEF;
        #1;
        chk("rd_en_rsp", 32'(dma_en_readresponse), 32'h1);
        chk("rd_wait_valid", 32'(rsp_valid), 32'h0);
        tick();
        dma_rdy_readresponse = 1'b0;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("rd_rsp_data", rsp_data, 32'hDEADBEEF);
        tick();
        chk("rd_hold_valid", 32'(rsp_valid), 32'h2);
        chk("rd_hold_cnt", read_count, 32'h0);
        rsp_ready = 4'h2;
        tick();
        rsp_ready = '0;
        chk("rd_done_valid", 32'(rsp_valid), 32'h0);
        chk("rd_cnt1", read_count, 32'h1);

        // Fairness: all four write continuously, ptr=1 so 2,3,0,1,2,3,0,1
        for (int i = 0; i < NC; i++) begin
            put(i, 1'b1, 32'h100 + i, 32'h200 + i, 32'h300 + i, 4'hF);
        end
        for (int k = 0; k < 8; k++) begin
            int e;
            e = (2 + k) % NC;
            #1;
            chk("fair_ready", 32'(req_ready), 32'(1 << e));
            chk("fair_handle", dma_write32_handle, 32'h100 + e);
            tick();
        end
        clr();
        chk("fair_wr_cnt", write_count, 32'd9);

        // Blocked read: client 0 reads, client 3 writes, read request port not ready
        dma_rdy_readrequest = 1'b0;
        put(0, 1'b0, 32'h5, 32'h20, 32'h0, 4'h0);
        put(3, 1'b1, 32'h9, 32'h30, 32'h1234, 4'h3);
        #1;
        chk("blk_ready_w", 32'(req_ready), 32'h8);
        chk("blk_wr_addr", dma_write32_addr, 32'h30);
        chk("blk_wr_be", 32'(dma_write32_byteenable), 32'h3);
        chk("blk_no_rd", 32'(dma_en_readrequest), 32'h0);
        tick();
        req_valid[3] = 1'b0;
        #1;
        chk("blk_wait1", 32'(req_ready), 32'h0);
        tick();
        chk("blk_wait2", 32'(req_ready), 32'h0);
        dma_rdy_readrequest = 1'b1;
        #1;
        chk("blk_ready_r", 32'(req_ready), 32'h1);
        chk("blk_rd_addr", dma_readrequest_addr, 32'h20);
        chk("blk_wr_cnt", write_count, 32'd10);
        tick();
        clr();

        // Timeout: read from client 0 never answered for TMO cycles; client 1 write waits
        put(1, 1'b1, 32'h55, 32'h50, 32'h5, 4'hF);
        for (int k = 1; k <= TMO; k++) begin
            #1;
            chk("to_not_yet", 32'(timeout_err), 32'h0);
            chk("to_no_grant", 32'(req_ready), 32'h0);
            tick();
        end
        chk("to_set", 32'(timeout_err), 32'h1);
        chk("to_no_grant2", 32'(req_ready), 32'h0);
        chk("to_no_valid", 32'(rsp_valid), 32'h0);
        dma_rdy_readresponse  = 1'b1;
        dma_readresponse_data = 32'hCAFEF00D;
        #1;
        chk("to_en_rsp", 32'(dma_en_readresponse), 32'h1);
        tick();
        dma_rdy_readresponse = 1'b0;
        chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("to_rsp_data", rsp_data, 32'hCAFEF00D);
        chk("to_dlv_nogrant", 32'(req_ready), 32'h0);
        rsp_ready = 4'h1;
        tick();
        rsp_ready = '0;
        chk("to_rd_cnt", read_count, 32'd2);
        chk("to_then_write", 32'(req_ready), 32'h2);
        chk("to_wr_addr", dma_write32_addr, 32'h50);
        tick();
        clr();
        chk("to_wr_cnt", write_count, 32'd11);
        chk("to_sticky", 32'(timeout_err), 32'h1);

        // Reset mid-read, stale response drained afterwards
        put(2, 1'b0, 32'h3, 32'h40, 32'h0, 4'h0);
        #1;
        chk("mr_ready", 32'(req_ready), 32'h4);
        tick();
        clr();
        RST = 1'b1;
        tick();
        chk("mr_rst_timeout", 32'(timeout_err), 32'h0);
        chk("mr_rst_wr_cnt", write_count, 32'h0);
        chk("mr_rst_rd_cnt", read_count, 32'h0);
        RST                   = 1'b0;
        dma_rdy_readresponse  = 1'b1;
        dma_readresponse_data = 32'hBAD0BAD0;
        put(1, 1'b0, 32'h11, 32'h44, 32'h0, 4'h0);
        put(3, 1'b1, 32'h33, 32'h60, 32'h77, 4'hF);
        #1;
        chk("mr_drain_en", 32'(dma_en_readresponse), 32'h1);
        chk("mr_drain_wr_only", 32'(req_ready), 32'h8);
        chk("mr_drain_no_rd", 32'(dma_en_readrequest), 32'h0);
        chk("mr_drain_valid", 32'(rsp_valid), 32'h0);
        tick();
        dma_rdy_readresponse = 1'b0;
        req_valid[3]         = 1'b0;
        #1;
        chk("mr_rd_ready", 32'(req_ready), 32'h2);
        chk("mr_rd_addr", dma_readrequest_addr, 32'h44);
        chk("mr_rd_handle", dma_readrequest_handle, 32'h11);
        chk("mr_wr_cnt", write_count, 32'h1);
        chk("mr_no_valid", 32'(rsp_valid), 32'h0);
        tick();
        clr();
        #1;
        chk("mr_wait_valid", 32'(rsp_valid), 32'h0);
        dma_rdy_readresponse  = 1'b1;
        dma_readresponse_data = 32'h600DF00D;
        tick();
        dma_rdy_readresponse = 1'b0;
        chk("mr_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("mr_rsp_data", rsp_data, 32'h600DF00D);
        rsp_ready = 4'h2;
        tick();
        rsp_ready = '0;
        chk("mr_rd_cnt", read_count, 32'h1);
        chk("mr_end_valid", 32'(rsp_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xsim_dma_arbiter.md
# xsim_dma_arbiter

Round-robin arbiter that shares the single simulation DMA port (read-request/read-response/write32 interface of the xsim DMA model) among NCLIENTS requesters. It sits between the per-client memory engines and the DMA model in the xsim top-level. Only one read is outstanding at a time, and read data is routed back to its owner. It also keeps read/write counters and a sticky response-timeout flag for debug.

## Interface
- NCLIENTS, 4: number of requesters, 2..16.
- TIMEOUT, 1024: maximum cycles allowed in WAIT_RSP before `timeout_err` is set.
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- req_valid  in  NCLIENTS  per-client request valid.
- req_ready  out  NCLIENTS  per-client grant/accept; at most one bit high.
- req_write  in  NCLIENTS  1 = write32, 0 = read.
- req_handle, req_addr, req_data  in  32*NCLIENTS each  packed per-client fields; client i occupies bits [32i+31:32i].
- req_be  in  4*NCLIENTS  byte enables, used for writes only.
- rsp_valid  out  NCLIENTS  read data valid for the owning client.
- rsp_ready  in  NCLIENTS  client accepts read data.
- rsp_data  out  32  read data, shared by all clients.
- dma_rdy_readrequest  in  1  from the DMA model.
- dma_en_readrequest  out  1  to the DMA model.
- dma_readrequest_addr, dma_readrequest_handle  out  32 each  to the DMA model.
- dma_rdy_readresponse  in  1  from the DMA model.
- dma_en_readresponse  out  1  to the DMA model.
- dma_readresponse_data  in  32  from the DMA model.
- dma_en_write32  out  1  to the DMA model.
- dma_write32_addr, dma_write32_handle, dma_write32_data  out  32 each  to the DMA model.
- dma_write32_byteenable  out  4  to the DMA model.
- read_count, write_count  out  32 each  completed reads and issued writes; wrap modulo 2^32.
- timeout_err  out  1  sticky flag; cleared only by RST.

## Operation
- **FSM states:** IDLE, WAIT_RSP, DELIVER.
- **IDLE, eligibility:**
  - A write requester is eligible when req_valid is high.
  - A read requester is eligible when req_valid is high and dma_rdy_readrequest is high.
- **IDLE, grant selection:** round-robin starting at ptr+1 (mod NCLIENTS). The winner g gets req_ready[g]=1 combinationally in the same cycle, and ptr updates to g.
- **Write grant:**
  - dma_en_write32=1 in the same cycle; the address, handle, data and byteenable fields are driven from client g.
  - write_count increments; the FSM stays in IDLE.
- **Read grant:**
  - dma_en_readrequest=1 in the same cycle, with addr/handle from client g.
  - owner is set to g; the FSM moves to WAIT_RSP and wait_cnt is cleared.
- **Stale response drain (IDLE only):** if dma_rdy_readresponse=1 in IDLE, the arbiter asserts dma_en_readresponse, discards the data, and grants no reads that cycle. Writes may still be granted.
- **WAIT_RSP:**
  - When dma_rdy_readresponse=1: latch dma_readresponse_data into rsp_data, pulse dma_en_readresponse, and move to DELIVER.
  - Otherwise wait_cnt increments. When wait_cnt reaches TIMEOUT, timeout_err is set and the FSM keeps waiting (no abort).
- **DELIVER:**
  - rsp_valid[owner]=1, all other rsp_valid bits 0.
  - When rsp_ready[owner]=1: read_count increments and the FSM returns to IDLE.
- **No grants outside IDLE:** req_ready is 0 in WAIT_RSP and DELIVER.
- **Unused ports:** req_data and req_be of read requests are ignored. Requests are never reordered within a client.

## Timing
- **Reset:** on RST=1 at a CLK edge:
  - state=IDLE and ptr=NCLIENTS-1, so client 0 wins first.
  - owner=0, wait_cnt=0, rsp_data=0, both counters 0, timeout_err=0.
  - All valid/enable outputs go to 0 from the first reset cycle. Combinational outputs are forced to 0 while RST=1.
- **Reset mid-read:** the in-flight read is abandoned. A stale response still held by the DMA model is drained by the IDLE rule.
- **Write latency:** request accepted at cycle T → dma_en_write32 at cycle T.
- **Read latency (minimum):**
  - Grant at cycle T; DMA model response available at T+1.
  - Latched and dma_en_readresponse pulsed at T+1.
  - rsp_valid at T+2; IDLE again at T+3 if rsp_ready is high at T+2.
- **Simultaneous requests:** exactly one grant per cycle, with reads and writes arbitrated jointly. A read winner blocked by dma_rdy_readrequest=0 is skipped and the search continues.
- **Starvation:** a continuously requesting client is granted within NCLIENTS grant opportunities.
- **Counters:** wrap from 0xFFFFFFFF to 0 silently.

## Structure
- **Package xsim_dma_arb_pkg:** state enum (IDLE, WAIT_RSP, DELIVER), DMA_WORD_W=32, DMA_BE_W=4.
- **Sub-module xsim_rr_arbiter:**
  - Parameter N; inputs req[N] and ptr; outputs one-hot gnt and gnt_idx.
  - Purely combinational; reused for other xsim shared resources.
- **Top-level contents:** FSM, owner/ptr registers, counters, timeout logic and the per-client field muxes.

## Test plan
- **Single write:** after reset, client 2 writes handle=1, addr=0x10, data=0xDEADBEEF, be=0xF → dma_en_write32 in the same cycle with those fields; write_count=1.
- **Single read:** client 1 reads addr=0x10 (model returns 0xDEADBEEF) → rsp_valid[1] two cycles after grant with rsp_data=0xDEADBEEF; read_count=1.
- **Fairness:** all 4 clients hold req_valid (writes) continuously → grants in order 0,1,2,3,0,…; no client waits more than 4 cycles.
- **Blocked read:** hold dma_rdy_readrequest=0 while client 0 reads and client 3 writes → client 3 is granted and client 0 waits; client 0 is granted once rdy returns.
- **Timeout:** TIMEOUT=8 and a model that never responds → timeout_err=1 after 8 WAIT_RSP cycles; no further grants; a later response is still delivered.
- **Reset mid-read:** assert RST in WAIT_RSP, with the model response arriving after reset → the response is drained in IDLE, no rsp_valid is asserted, and the next read returns correct data.
